// File: rtl/cdc_wr_arb.sv
// cdc_wr_arb: round-robin burst scheduler feeding the cdc write port.
// One owner at a time, bursts capped at MAX_BURST, IDLE_GAP dead cycles between.
module cdc_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int IDLE_GAP  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    iv_src_valid,
    input  logic [NUM_REQ*DW-1:0] iv_src_data,
    input  logic [NUM_REQ-1:0]    iv_src_last,
    output logic [NUM_REQ-1:0]    ov_src_ready,
    input  logic                  i_cdc_afull,
    output logic [DW-1:0]         ov_data,
    output logic                  o_data_wr,
    output logic [NUM_REQ-1:0]    ov_grant,
    output logic                  o_busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LP_MAXM1 = 8'(MAX_BURST - 1);
    localparam logic [3:0] LP_GAPM1 = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_gidx;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_ptr_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_beat_cnt;
    logic [3:0]          r_gap_cnt;
    logic [DW-1:0]       r_data;
    logic                r_wr;
    logic                w_any;
    logic                w_beat;
    logic                w_end;
    logic [DW-1:0]       w_gdata;
    logic                w_glast;

    // First requester at or after ptr, searching upward with wrap.
    function automatic logic [PW-1:0] f_pick(
        input logic [PW-1:0]      ptr,
        input logic [NUM_REQ-1:0] req
    );
        int            k;
        logic [PW-1:0] kk;
        f_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k  = (int'(ptr) + i) % NUM_REQ;
            kk = PW'(k);
            if (req[kk]) f_pick = kk;
        end
    endfunction

    // Owner-side data/last mux and handshake decode.
    always_comb begin
        w_gdata = '0;
        w_glast = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_gidx == PW'(k)) begin
                w_gdata = iv_src_data[k*DW +: DW];
                w_glast = iv_src_last[k];
            end
        end
        w_any        = |iv_src_valid;
        w_win        = f_pick(r_ptr, iv_src_valid);
        ov_src_ready = (r_state == S_XFER && !i_cdc_afull) ? r_grant : '0;
        w_beat       = |(iv_src_valid & ov_src_ready);
        w_end        = w_beat & (w_glast | (r_beat_cnt == LP_MAXM1));
        w_ptr_nxt    = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_any) w_state_nxt = S_XFER;
            S_XFER: begin
                if (w_end) w_state_nxt = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: if (r_gap_cnt == LP_GAPM1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Grant, pointer, counters and the registered write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
        end else begin
            r_wr <= w_beat;
            if (w_beat) begin
                r_data     <= w_gdata;
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_gap_cnt <= '0;
                    if (w_any) begin
                        r_gidx  <= w_win;
                        r_grant <= NUM_REQ'(1) << w_win;
                    end
                end
                S_XFER: begin
                    if (w_end) begin
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                        r_ptr      <= w_ptr_nxt;
                    end
                end
                S_GAP: r_gap_cnt <= r_gap_cnt + 4'd1;
                default: r_gap_cnt <= '0;
            endcase
        end
    end

    assign ov_data   = r_data;
    assign o_data_wr = r_wr;
    assign ov_grant  = r_grant;
    assign o_busy    = (r_state != S_IDLE);

endmodule
